// File: rtl/chan_mux_rr_pkg.sv
// Shared definitions for the chan_mux_rr stream multiplexer.
// Mode encoding and the round-robin pointer advance rule.
package chan_mux_rr_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Pointer moves one past the granted channel, wrapping at nch-1.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned nch);
      return (idx == nch - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: grants the first requester at or after ptr,
// wrapping to channel 0. The pointer itself is owned by the caller.
module rr_arbiter #(
   parameter int unsigned NCH = 8,
   localparam int unsigned SW = $clog2(NCH)
) (
   input  logic [NCH-1:0] req,
   input  logic [SW-1:0]  ptr,
   input  logic           en,
   output logic [NCH-1:0] gnt_onehot,
   output logic [SW-1:0]  gnt_idx,
   output logic           gnt_any
);

   logic [NCH-1:0] hi_mask;
   logic [NCH-1:0] req_hi;
   logic [NCH-1:0] pick;

   always_comb begin
      hi_mask = '0;
      for (int j = 0; j < NCH; j++) begin
         hi_mask[j] = (j >= int'(ptr));
      end
   end

   assign req_hi = req & hi_mask;

   // Requests at/above ptr win; otherwise fall back to the lowest overall (the wrap).
   always_comb begin
      gnt_onehot = '0;
      gnt_idx    = '0;
      gnt_any    = 1'b0;
      pick       = '0;
      if (en) begin
         pick = (|req_hi) ? req_hi : req;
         for (int j = NCH - 1; j >= 0; j--) begin
            if (pick[j]) begin
               gnt_idx = SW'(j);
            end
         end
         gnt_any    = |pick;
         gnt_onehot = pick & (~pick + 1'b1);
      end
   end

endmodule

// File: rtl/chan_mux_rr.sv
// NCH-channel registered stream multiplexer with valid/ready handshake and
// selectable fixed-select or round-robin arbitration.
module chan_mux_rr
   import chan_mux_rr_pkg::*;
#(
   parameter int unsigned NCH = 8,
   parameter int unsigned W   = 8,
   localparam int unsigned SW = $clog2(NCH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mode,
   input  logic [SW-1:0]    sel,
   input  logic [NCH*W-1:0] in_data,
   input  logic [NCH-1:0]   in_valid,
   output logic [NCH-1:0]   in_ready,
   output logic [W-1:0]     out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SW-1:0]    out_ch
);

   localparam logic [SW:0] NchW = (SW + 1)'(NCH);

   logic [SW-1:0]  ptr_q, ptr_d;
   logic           out_valid_q, out_valid_d;
   logic [W-1:0]   out_data_q, out_data_d;
   logic [SW-1:0]  out_ch_q, out_ch_d;

   logic           is_rr;
   logic           sel_ok;
   logic           fix_any;
   logic [NCH-1:0] fix_onehot;
   logic [NCH-1:0] rr_onehot;
   logic [SW-1:0]  rr_idx;
   logic           rr_any;
   logic           gnt_any;
   logic [SW-1:0]  gnt_idx;
   logic [NCH-1:0] gnt_onehot;
   logic           can_load;
   logic           load;
   logic [W-1:0]   mux_data;

   assign is_rr  = (mode == MODE_RR);
   assign sel_ok = ({1'b0, sel} < NchW);

   rr_arbiter #(
      .NCH (NCH)
   ) u_arb (
      .req        (in_valid),
      .ptr        (ptr_q),
      .en         (is_rr),
      .gnt_onehot (rr_onehot),
      .gnt_idx    (rr_idx),
      .gnt_any    (rr_any)
   );

   // Out-of-range sel never grants, even when NCH is not a power of two.
   always_comb begin
      fix_any    = 1'b0;
      fix_onehot = '0;
      if (sel_ok) begin
         fix_any = in_valid[sel];
      end
      for (int j = 0; j < NCH; j++) begin
         fix_onehot[j] = fix_any && (sel == SW'(j));
      end
   end

   always_comb begin
      gnt_any    = fix_any;
      gnt_idx    = sel;
      gnt_onehot = fix_onehot;
      if (is_rr) begin
         gnt_any    = rr_any;
         gnt_idx    = rr_idx;
         gnt_onehot = rr_onehot;
      end
   end

   assign can_load = !out_valid_q || out_ready;
   assign load     = gnt_any && can_load;
   assign in_ready = gnt_onehot & {NCH{can_load}};

   always_comb begin
      mux_data = '0;
      for (int k = 0; k < NCH; k++) begin
         if (gnt_idx == SW'(k)) begin
            mux_data = in_data[k*W +: W];
         end
      end
   end

   // Data/ch hold their last value after a drain; only valid falls.
   always_comb begin
      out_valid_d = load || (out_valid_q && !out_ready);
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      ptr_d       = ptr_q;
      if (load) begin
         out_data_d = mux_data;
         out_ch_d   = gnt_idx;
         if (is_rr) begin
            ptr_d = SW'(rr_next(32'(gnt_idx), NCH));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
      end else begin
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_chan_mux_rr.sv
// Directed bench for chan_mux_rr: an 8-channel instance for the main behaviour and
// a 5-channel instance for out-of-range select and non-power-of-two wrap.
module tb_chan_mux_rr;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        mode_a, out_ready_a, out_valid_a;
   logic [2:0]  sel_a, out_ch_a;
   logic [63:0] in_data_a;
   logic [7:0]  in_valid_a, in_ready_a, out_data_a;

   logic        mode_b, out_ready_b, out_valid_b;
   logic [2:0]  sel_b, out_ch_b;
   logic [39:0] in_data_b;
   logic [4:0]  in_valid_b, in_ready_b;
   logic [7:0]  out_data_b;

   int n_err = 0;
   int n_chk = 0;

   chan_mux_rr #(.NCH(8), .W(8)) u_dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode_a),
      .sel       (sel_a),
      .in_data   (in_data_a),
      .in_valid  (in_valid_a),
      .in_ready  (in_ready_a),
      .out_data  (out_data_a),
      .out_valid (out_valid_a),
      .out_ready (out_ready_a),
      .out_ch    (out_ch_a)
   );

   chan_mux_rr #(.NCH(5), .W(8)) u_dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode_b),
      .sel       (sel_b),
      .in_data   (in_data_b),
      .in_valid  (in_valid_b),
      .in_ready  (in_ready_b),
      .out_data  (out_data_b),
      .out_valid (out_valid_b),
      .out_ready (out_ready_b),
      .out_ch    (out_ch_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n       = 1'b0;
      mode_a      = 1'b0;
      sel_a       = 3'd0;
      in_valid_a  = 8'h00;
      out_ready_a = 1'b1;
      mode_b      = 1'b0;
      sel_b       = 3'd0;
      in_valid_b  = 5'h00;
      out_ready_b = 1'b1;
      for (int k = 0; k < 8; k++) in_data_a[k*8 +: 8] = 8'hA0 + 8'(k);
      for (int k = 0; k < 5; k++) in_data_b[k*8 +: 8] = 8'hB0 + 8'(k);
      #1;
      chk("rst_valid", 32'(out_valid_a), 32'h0);
      chk("rst_data", 32'(out_data_a), 32'h0);
      chk("rst_ch", 32'(out_ch_a), 32'h0);
      tick;
      tick;
      rst_n = 1'b1;

      // Fixed select ch5
      mode_a     = 1'b0;
      sel_a      = 3'd5;
      in_valid_a = 8'hFF;
      #1;
      chk("fix_rdy", 32'(in_ready_a), 32'h20);
      tick;
      chk("fix_valid", 32'(out_valid_a), 32'h1);
      chk("fix_data", 32'(out_data_a), 32'hA5);
      chk("fix_ch", 32'(out_ch_a), 32'h5);

      // Round-robin fairness, all channels valid; ptr still 0 after fixed mode
      mode_a = 1'b1;
      #1;
      for (int i = 0; i < 10; i++) begin
         chk("rr_rdy", 32'(in_ready_a), 32'(1 << (i % 8)));
         tick;
         chk("rr_valid", 32'(out_valid_a), 32'h1);
         chk("rr_ch", 32'(out_ch_a), 32'(i % 8));
         chk("rr_data", 32'(out_data_a), 32'(8'hA0 + 8'(i % 8)));
      end

      // Skip and wrap with ptr=2
      in_valid_a = 8'b1000_0010;
      #1;
      chk("skip_rdy7", 32'(in_ready_a), 32'h80);
      tick;
      chk("skip_ch7", 32'(out_ch_a), 32'h7);
      chk("wrap_rdy1", 32'(in_ready_a), 32'h02);
      tick;
      chk("wrap_ch1", 32'(out_ch_a), 32'h1);
      chk("skip_rdy7b", 32'(in_ready_a), 32'h80);
      tick;
      chk("skip_ch7b", 32'(out_ch_a), 32'h7);
      chk("skip_data7b", 32'(out_data_a), 32'hA7);

      // Backpressure, with a mode switch while stalled
      out_ready_a = 1'b0;
      #1;
      chk("bp_rdy0", 32'(in_ready_a), 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick;
         if (i == 0) begin
            mode_a = 1'b0;
            sel_a  = 3'd1;
            #1;
         end
         chk("bp_valid", 32'(out_valid_a), 32'h1);
         chk("bp_data", 32'(out_data_a), 32'hA7);
         chk("bp_ch", 32'(out_ch_a), 32'h7);
         chk("bp_rdy", 32'(in_ready_a), 32'h0);
      end
      out_ready_a = 1'b1;
      #1;
      chk("bp_rel_rdy", 32'(in_ready_a), 32'h02);
      tick;
      chk("bp_rel_ch", 32'(out_ch_a), 32'h1);
      chk("bp_rel_data", 32'(out_data_a), 32'hA1);
      chk("bp_rel_valid", 32'(out_valid_a), 32'h1);

      // Drain with nothing to load
      in_valid_a = 8'h00;
      #1;
      chk("drain_rdy", 32'(in_ready_a), 32'h0);
      tick;
      chk("drain_valid", 32'(out_valid_a), 32'h0);
      chk("drain_data", 32'(out_data_a), 32'hA1);
      chk("drain_ch", 32'(out_ch_a), 32'h1);

      // Advance ptr to 1, then reset mid-stream
      mode_a     = 1'b1;
      in_valid_a = 8'hFF;
      #1;
      chk("pre_rdy", 32'(in_ready_a), 32'h01);
      tick;
      chk("pre_ch", 32'(out_ch_a), 32'h0);
      chk("pre_ptr_rdy", 32'(in_ready_a), 32'h02);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid_a), 32'h0);
      chk("mid_rst_data", 32'(out_data_a), 32'h0);
      chk("mid_rst_ch", 32'(out_ch_a), 32'h0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_rdy", 32'(in_ready_a), 32'h01);
      tick;
      chk("post_rst_ch", 32'(out_ch_a), 32'h0);
      chk("post_rst_valid", 32'(out_valid_a), 32'h1);

      // NCH=5: out-of-range select never grants
      sel_b      = 3'd6;
      in_valid_b = 5'h1F;
      #1;
      chk("b_oor_rdy", 32'(in_ready_b), 32'h0);
      tick;
      chk("b_oor_valid1", 32'(out_valid_b), 32'h0);
      tick;
      chk("b_oor_valid2", 32'(out_valid_b), 32'h0);
      sel_b = 3'd4;
      #1;
      chk("b_sel4_rdy", 32'(in_ready_b), 32'h10);
      tick;
      chk("b_sel4_ch", 32'(out_ch_b), 32'h4);
      chk("b_sel4_data", 32'(out_data_b), 32'hB4);

      // NCH=5 round-robin wrap from the last channel
      mode_b     = 1'b1;
      in_valid_b = 5'b10000;
      #1;
      chk("b_rr_rdy4", 32'(in_ready_b), 32'h10);
      tick;
      chk("b_rr_ch4", 32'(out_ch_b), 32'h4);
      in_valid_b = 5'b10001;
      #1;
      chk("b_rr_wrap_rdy", 32'(in_ready_b), 32'h01);
      tick;
      chk("b_rr_wrap_ch", 32'(out_ch_b), 32'h0);
      chk("b_rr_wrap_data", 32'(out_data_b), 32'hB0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
